// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU widths, exponent constant and normaliser flag bundle
package fpu_pkg;

  localparam int MANT_W_DFLT = 23;
  localparam int EXP_W_DFLT  = 8;

  localparam logic [EXP_W_DFLT-1:0] EXP_MAX = '1;

  typedef struct packed {
    logic zero;
    logic uflow;
    logic ovf;
  } norm_flags_t;

endpackage

// File: rtl/fpu_lzc.sv
// rtl/fpu_lzc.sv - combinational leading-zero counter, MSB first, with all-zero flag
module fpu_lzc #(
  parameter int WIDTH = 25,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  // Scanning upward lets the highest set bit win; count reads 0 when the input is zero.
  always_comb begin
    cnt_o  = '0;
    zero_o = (data_i == '0);
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) cnt_o = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fpu_norm_pipe.sv
// rtl/fpu_norm_pipe.sv - two-stage post-add normaliser with valid/ready flow control
// Optional out_sticky port when FPU_NORM_STICKY_EN is defined.
module fpu_norm_pipe
  import fpu_pkg::*;
#(
  parameter int MANT_W = MANT_W_DFLT,
  parameter int EXP_W  = EXP_W_DFLT,
  parameter int IN_W   = MANT_W + 2,
  parameter int CNT_W  = $clog2(IN_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_sum,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic [CNT_W-1:0]  out_shift,
  output logic              out_zero,
  output logic              out_uflow,
`ifdef FPU_NORM_STICKY_EN
  output logic              out_sticky,
`endif
  output logic              out_ovf
);

  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  logic s1_valid_q, s2_valid_q;
  logic s1_adv, s2_adv;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  logic [CNT_W-1:0] lz;
  logic             lz_zero;

  fpu_lzc #(.WIDTH(IN_W), .CNT_W(CNT_W)) u_lzc (
    .data_i (in_sum),
    .cnt_o  (lz),
    .zero_o (lz_zero)
  );

  logic [IN_W-1:0]  s1_sum_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [CNT_W-1:0] s1_shift_q, s1_shift_d;
  logic             s1_carry_q, s1_carry_d;
  norm_flags_t      s1_flags_q, s1_flags_d;
  int               s1_req, s1_lim;

  // Shift stops one short of the exponent so a limited result lands at the denormal boundary.
  always_comb begin
    s1_flags_d = '0;
    s1_shift_d = '0;
    s1_carry_d = in_sum[IN_W-1];
    s1_req     = int'(lz) - 1;
    s1_lim     = int'(in_exp) - 1;
    if (lz_zero) begin
      s1_flags_d.zero = 1'b1;
    end else if (!s1_carry_d && in_exp != '0) begin
      if (s1_req > s1_lim) begin
        s1_shift_d       = CNT_W'(s1_lim);
        s1_flags_d.uflow = 1'b1;
      end else begin
        s1_shift_d = CNT_W'(s1_req);
      end
    end
  end

  logic [MANT_W-1:0] out_mant_q, out_mant_d;
  logic [EXP_W-1:0]  out_exp_q, out_exp_d, exp_inc;
  logic [CNT_W-1:0]  out_shift_q, out_shift_d;
  norm_flags_t       out_flags_q, out_flags_d;
`ifdef FPU_NORM_STICKY_EN
  logic              out_sticky_q, out_sticky_d;
`endif

  always_comb begin
    exp_inc     = s1_exp_q + EXP_W'(1);
    out_mant_d  = '0;
    out_exp_d   = '0;
    out_shift_d = '0;
    out_flags_d = s1_flags_q;
`ifdef FPU_NORM_STICKY_EN
    out_sticky_d = 1'b0;
`endif
    if (s1_carry_q) begin
      out_mant_d      = s1_sum_q[IN_W-2:1];
      out_exp_d       = exp_inc;
      out_flags_d.ovf = (exp_inc == EXP_ONES);
      if (out_flags_d.ovf) out_mant_d = '0;
`ifdef FPU_NORM_STICKY_EN
      out_sticky_d = s1_sum_q[0];
`endif
    end else if (!s1_flags_q.zero) begin
      out_mant_d  = MANT_W'(s1_sum_q << s1_shift_q);
      out_exp_d   = s1_flags_q.uflow ? '0 : s1_exp_q - EXP_W'(s1_shift_q);
      out_shift_d = s1_shift_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      s1_exp_q    <= '0;
      s1_shift_q  <= '0;
      s1_carry_q  <= 1'b0;
      s1_flags_q  <= '0;
      out_mant_q  <= '0;
      out_exp_q   <= '0;
      out_shift_q <= '0;
      out_flags_q <= '0;
`ifdef FPU_NORM_STICKY_EN
      out_sticky_q <= 1'b0;
`endif
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_sum_q   <= in_sum;
          s1_exp_q   <= in_exp;
          s1_shift_q <= s1_shift_d;
          s1_carry_q <= s1_carry_d;
          s1_flags_q <= s1_flags_d;
        end
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_mant_q  <= out_mant_d;
          out_exp_q   <= out_exp_d;
          out_shift_q <= out_shift_d;
          out_flags_q <= out_flags_d;
`ifdef FPU_NORM_STICKY_EN
          out_sticky_q <= out_sticky_d;
`endif
        end
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_mant  = out_mant_q;
  assign out_exp   = out_exp_q;
  assign out_shift = out_shift_q;
  assign out_zero  = out_flags_q.zero;
  assign out_uflow = out_flags_q.uflow;
  assign out_ovf   = out_flags_q.ovf;
`ifdef FPU_NORM_STICKY_EN
  assign out_sticky = out_sticky_q;
`endif

endmodule
